// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO result registers and fixed latency:
// 5 cycles for MULT/MULTU and 10 for DIV/DIVU, plus single-cycle MTHI/MTLO writes.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic        w_accept;
    logic        w_done;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Datapath works only on the operands latched at acceptance.
    logic        w_mul_signed;
    logic        w_div_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_b_zero;

    assign w_mul_signed = (r_op == OP_MULT);
    assign w_div_signed = (r_op == OP_DIV);
    assign w_a_ext      = w_mul_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_b_ext      = w_mul_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    // The low 64 bits of the extended product are exact for both signednesses.
    assign w_prod       = w_a_ext * w_b_ext;

    // Signed division on magnitudes keeps 0x80000000 / -1 well defined.
    assign w_a_neg  = w_div_signed & r_a[31];
    assign w_b_neg  = w_div_signed & r_b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_b_mag  = w_b_neg ? (32'd0 - r_b) : r_b;
    assign w_b_zero = (r_b == 32'd0);
    assign w_q_mag  = w_b_zero ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag  = w_b_zero ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_quot   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (op[2] == 1'b0) w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == 4'd1) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 4'd0;
            r_op  <= 3'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else if (w_accept) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
            case (op)
                OP_MULT, OP_MULTU: r_cnt <= 4'd5;
                OP_DIV, OP_DIVU:   r_cnt <= 4'd10;
                OP_MTHI:           r_hi  <= a;
                OP_MTLO:           r_lo  <= a;
                default:           ;
            endcase
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - 4'd1;
            if (w_done) begin
                if (r_op[1] == 1'b0) begin
                    r_hi <= w_prod[63:32];
                    r_lo <= w_prod[31:0];
                end else if (!w_b_zero) begin
                    r_hi <= w_rem;
                    r_lo <= w_quot;
                end
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
